srl_fifo_unpacker: RTL and testbench
====================================

Name: srl_fifo_unpacker

Overview:
- Downstream drain stage for the SRL FIFO.
- Pops wide words from the FIFO's first-word-fall-through interface (EMPTY_N / DEQ / D_OUT) and emits them as a sequence of narrower beats on a valid/ready stream.
- Sits between the wide FIFO and a narrow consumer (e.g. a 32-bit message port). Sustains one beat per clock, with no bubble at word boundaries.

Parameters:
- width, 128, FIFO word width in bits; must be an exact multiple of ratio.
- ratio, 4, beats per FIFO word; 2..16. Narrow width wo = width/ratio.
- msb_first, 0: 0 = beat 0 is D_IN[wo-1:0] (LSB first); 1 = beat 0 is D_IN[width-1:width-wo].

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear; discards the held word.
- FIFO_EMPTY_N  in  1  upstream FIFO has a valid word on FIFO_D.
- FIFO_D  in  width  upstream FIFO head word; valid whenever FIFO_EMPTY_N=1.
- FIFO_DEQ  out  1  pop upstream FIFO this cycle (combinational).
- OUT_VALID  out  1  OUT_DATA holds a beat.
- OUT_READY  in  1  consumer accepts a beat this cycle.
- OUT_DATA  out  wo  current beat.
- OUT_LAST  out  1  current beat is the last beat of its word.
- BEAT_IDX  out  clog2(ratio)  index of the current beat within its word.

Behaviour:
- Registers:
  - hold[width-1:0]: shift register holding the word.
  - idx[clog2(ratio)-1:0]: beat counter.
  - vld: occupancy flag.
- States: EMPTY (vld=0) and BUSY (vld=1).
- Reset (RST_N low, asynchronous):
  - vld=0, idx=0, hold=0; OUT_VALID=0, OUT_LAST=0, BEAT_IDX=0, OUT_DATA=0.
  - FIFO_DEQ=0 while RST_N=0.
- accept = vld && OUT_READY. last = (idx==ratio-1).
- FIFO_DEQ = FIFO_EMPTY_N && !CLR && (!vld || (accept && last)).
- On FIFO_DEQ: hold<=FIFO_D, idx<=0, vld<=1. This load takes priority over the accept's vld clear, so back-to-back words run with no bubble.
- On accept && !last:
  - idx<=idx+1.
  - hold shifts by wo toward beat 0: right if msb_first=0, left if msb_first=1. Vacated bits fill with 0.
- On accept && last && !FIFO_DEQ: vld<=0, idx<=0 (EMPTY).
- No accept (OUT_VALID && !OUT_READY): hold, idx and vld stay stable. OUT_DATA must not change while stalled.
- OUT_DATA = hold[wo-1:0] (msb_first=0) or hold[width-1:width-wo] (msb_first=1). OUT_VALID=vld, OUT_LAST=vld&&last, BEAT_IDX=idx.
- Latency: FIFO_EMPTY_N high in cycle N with the block EMPTY → FIFO_DEQ in N → OUT_VALID in N+1.
- Throughput: with OUT_READY held high and the FIFO non-empty, OUT_VALID stays high continuously, one beat per clock. A word is popped every ratio cycles.
- CLR (synchronous, checked before all other updates): vld<=0, idx<=0. FIFO_DEQ forced 0 in the CLR cycle. A partially sent word is dropped; the FIFO contents are untouched.
- FIFO_EMPTY_N low while EMPTY: no pop, OUT_VALID stays 0.
- The block never pops when FIFO_EMPTY_N=0. FIFO_DEQ is only ever asserted in a cycle where the word is also loaded.
- idx wraps only via the load or last-beat paths. It never counts past ratio-1.
- Reset asserted mid-word: the beat and word are lost. After release the block restarts from EMPTY.
- The FIFO's registered EMPTY_N lags DEQ by one cycle. This is safe: FIFO_DEQ is qualified by FIFO_EMPTY_N in the same cycle only.

Test Plan:
- Single word, LSB first: FIFO holds 0x33333333_22222222_11111111_00000000, OUT_READY=1 → FIFO_DEQ one cycle. Next 4 cycles OUT_DATA = 0x00000000, 0x11111111, 0x22222222, 0x33333333; OUT_LAST only on the 4th beat; then OUT_VALID=0.
- Streaming: 3 words preloaded, OUT_READY=1 → 12 consecutive valid beats with no gap. FIFO_DEQ pulses in the cycles of beat 3 and beat 7 (0-based), alongside the initial pop.
- Backpressure: OUT_READY toggles 1,0,0,1,… → OUT_DATA and BEAT_IDX hold steady during stalls. All 4 beats are delivered in order. No FIFO_DEQ until the last beat is accepted.
- msb_first=1, same word as the first scenario → beats 0x33333333, 0x22222222, 0x11111111, 0x00000000.
- CLR after beat 1 accepted: next cycle OUT_VALID=0. With the FIFO still non-empty, the following cycle pops the next word and restarts at BEAT_IDX=0.
- Async reset mid-word: drop RST_N between clock edges → OUT_VALID, FIFO_DEQ, BEAT_IDX go 0 immediately. After release, there is no pop until FIFO_EMPTY_N=1.

Source files
------------

// File: rtl/srl_fifo_unpacker_if.sv
// Handshake bundle between the wide SRL FIFO head, the unpacker and the narrow consumer.
// The unpacker takes the slave view; the surrounding logic (or bench) takes the master view.
interface srl_fifo_unpacker_if #(
  parameter int width = 128,
  parameter int ratio = 4
);
  localparam int wo = width / ratio;
  localparam int iw = $clog2(ratio);

  logic             CLR;
  logic             FIFO_EMPTY_N;
  logic [width-1:0] FIFO_D;
  logic             FIFO_DEQ;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [wo-1:0]    OUT_DATA;
  logic             OUT_LAST;
  logic [iw-1:0]    BEAT_IDX;

  modport master (
    output CLR, FIFO_EMPTY_N, FIFO_D, OUT_READY,
    input  FIFO_DEQ, OUT_VALID, OUT_DATA, OUT_LAST, BEAT_IDX
  );

  modport slave (
    input  CLR, FIFO_EMPTY_N, FIFO_D, OUT_READY,
    output FIFO_DEQ, OUT_VALID, OUT_DATA, OUT_LAST, BEAT_IDX
  );
endinterface

// File: rtl/srl_fifo_unpacker.sv
// Drains wide words from a first-word-fall-through FIFO and emits them as ratio narrow
// beats on a valid/ready stream, reloading on the last beat so words run back to back.
module srl_fifo_unpacker #(
  parameter int width     = 128,
  parameter int ratio     = 4,
  parameter bit msb_first = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  srl_fifo_unpacker_if.slave bus
);
  localparam int wo = width / ratio;
  localparam int iw = $clog2(ratio);

  localparam logic [0:0]    ST_EMPTY = 1'b0;
  localparam logic [0:0]    ST_BUSY  = 1'b1;
  localparam logic [iw-1:0] IDX_LAST = iw'(ratio - 1);

  logic [width-1:0] hold;
  logic [iw-1:0]    idx;
  logic [0:0]       vld;

  logic accept;
  logic last;
  logic deq;

  assign accept = (vld == ST_BUSY) && bus.OUT_READY;
  assign last   = (idx == IDX_LAST);

  // Pop only when the word can be loaded in the same edge: either nothing is held or the
  // last beat is leaving now. RST_N gating keeps the FIFO untouched while in reset.
  assign deq = RST_N && bus.FIFO_EMPTY_N && !bus.CLR &&
               ((vld == ST_EMPTY) || (accept && last));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values of its neighbours, independent of block evaluation order.
      vld  <= ST_EMPTY;
      idx  <= '0;
      hold <= '0;
    end else if (bus.CLR) begin
      vld <= ST_EMPTY;
      idx <= '0;
    end else if (deq) begin
      hold <= bus.FIFO_D;
      idx  <= '0;
      vld  <= ST_BUSY;
    end else if (accept) begin
      if (!last) begin
        idx  <= idx + 1'b1;
        hold <= msb_first ? (hold << wo) : (hold >> wo);
      end else begin
        vld <= ST_EMPTY;
        idx <= '0;
      end
    end
  end

  assign bus.FIFO_DEQ  = deq;
  assign bus.OUT_VALID = (vld == ST_BUSY);
  assign bus.OUT_LAST  = (vld == ST_BUSY) && last;
  assign bus.BEAT_IDX  = idx;
  assign bus.OUT_DATA  = msb_first ? hold[width-1 -: wo] : hold[wo-1:0];
endmodule

// File: tb/tb_srl_fifo_unpacker.sv
// Directed bench for srl_fifo_unpacker: one LSB-first and one MSB-first instance, each fed
// by a queue-modelled FWFT FIFO, with hand-computed beat expectations.
module tb_srl_fifo_unpacker;
  localparam int W  = 128;
  localparam int R  = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  srl_fifo_unpacker_if #(.width(W), .ratio(R)) bus_a ();
  srl_fifo_unpacker_if #(.width(W), .ratio(R)) bus_b ();

  srl_fifo_unpacker #(.width(W), .ratio(R), .msb_first(1'b0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_a)
  );
  srl_fifo_unpacker #(.width(W), .ratio(R), .msb_first(1'b1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_b)
  );

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus_a.FIFO_EMPTY_N = (qa.size() != 0);
    bus_a.FIFO_D       = (qa.size() != 0) ? qa[0] : '0;
    bus_b.FIFO_EMPTY_N = (qb.size() != 0);
    bus_b.FIFO_D       = (qb.size() != 0) ? qb[0] : '0;
  endtask

  // Advance one clock; the FIFO model pops when DEQ was high just before the edge.
  task automatic cyc();
    logic da, db;
    da = bus_a.FIFO_DEQ;
    db = bus_b.FIFO_DEQ;
    @(posedge CLK);
    #1;
    if (da && qa.size() != 0) qa.delete(0);
    if (db && qb.size() != 0) qb.delete(0);
    drive_fifo();
  endtask

  logic [W-1:0] w1;
  logic [W-1:0] sw [3];
  logic [W-1:0] cur;
  logic [31:0]  bp_beats [4];
  logic [31:0]  lsb_beats [4];
  logic [31:0]  msb_beats [4];
  bit           rdy_pat [10];

  initial begin
    w1        = 128'h33333333_22222222_11111111_00000000;
    sw[0]     = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    sw[1]     = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    sw[2]     = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    lsb_beats = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
    msb_beats = '{32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    bp_beats  = '{32'h9ABCDEF0, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
    rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with a word already waiting: nothing may pop.
    RST_N = 1'b0;
    bus_a.CLR = 1'b0; bus_a.OUT_READY = 1'b0;
    bus_b.CLR = 1'b0; bus_b.OUT_READY = 1'b0;
    qa.push_back(w1);
    drive_fifo();
    #3;
    check("rst_valid", 32'(bus_a.OUT_VALID), 0);
    check("rst_last",  32'(bus_a.OUT_LAST), 0);
    check("rst_idx",   32'(bus_a.BEAT_IDX), 0);
    check("rst_data",  bus_a.OUT_DATA, 0);
    check("rst_deq",   32'(bus_a.FIFO_DEQ), 0);
    check("rst_data_b", bus_b.OUT_DATA, 0);
    cyc();
    cyc();
    RST_N = 1'b1;

    // CLR blocks the pop even while EMPTY with the FIFO non-empty.
    bus_a.CLR = 1'b1; bus_a.OUT_READY = 1'b1;
    #1;
    check("clr_blocks_deq", 32'(bus_a.FIFO_DEQ), 0);
    cyc();
    bus_a.CLR = 1'b0;
    #1;
    check("clr_no_load_valid", 32'(bus_a.OUT_VALID), 0);
    check("s1_deq", 32'(bus_a.FIFO_DEQ), 1);
    cyc();

    // Single word, LSB first.
    for (int k = 0; k < R; k++) begin
      #1;
      check("s1_valid", 32'(bus_a.OUT_VALID), 1);
      check("s1_data",  bus_a.OUT_DATA, lsb_beats[k]);
      check("s1_idx",   32'(bus_a.BEAT_IDX), k);
      check("s1_last",  32'(bus_a.OUT_LAST), (k == R - 1) ? 1 : 0);
      cyc();
    end
    #1;
    check("s1_idle_valid", 32'(bus_a.OUT_VALID), 0);
    check("s1_idle_deq",   32'(bus_a.FIFO_DEQ), 0);
    cyc();

    // Streaming three words with no bubble.
    for (int i = 0; i < 3; i++) qa.push_back(sw[i]);
    drive_fifo();
    #1;
    check("st_first_deq", 32'(bus_a.FIFO_DEQ), 1);
    cyc();
    for (int k = 0; k < 3 * R; k++) begin
      cur = sw[k / R];
      #1;
      check("st_valid", 32'(bus_a.OUT_VALID), 1);
      check("st_data",  bus_a.OUT_DATA, cur[32 * (k % R) +: 32]);
      check("st_idx",   32'(bus_a.BEAT_IDX), k % R);
      check("st_last",  32'(bus_a.OUT_LAST), (k % R == R - 1) ? 1 : 0);
      check("st_deq",   32'(bus_a.FIFO_DEQ), (k == 3 || k == 7) ? 1 : 0);
      cyc();
    end
    #1;
    check("st_idle_valid", 32'(bus_a.OUT_VALID), 0);
    cyc();

    // Backpressure, with a second word queued so a premature pop would show.
    qa.push_back(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    qa.push_back(128'h44444444_55555555_66666666_77777777);
    drive_fifo();
    #1;
    check("bp_load_deq", 32'(bus_a.FIFO_DEQ), 1);
    cyc();
    begin
      int b;
      b = 0;
      for (int c = 0; c < 10; c++) begin
        bus_a.OUT_READY = rdy_pat[c];
        #1;
        check("bp_valid", 32'(bus_a.OUT_VALID), 1);
        check("bp_data",  bus_a.OUT_DATA, bp_beats[b]);
        check("bp_idx",   32'(bus_a.BEAT_IDX), b);
        check("bp_deq",   32'(bus_a.FIFO_DEQ), (rdy_pat[c] && b == R - 1) ? 1 : 0);
        cyc();
        if (rdy_pat[c]) b++;
      end
      check("bp_all_beats", b, R);
    end

    // CLR after beat 1 accepted, then restart on the next queued word.
    qa.push_back(128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00);
    drive_fifo();
    bus_a.OUT_READY = 1'b1;
    #1;
    check("clr_b0_data", bus_a.OUT_DATA, 32'h77777777);
    cyc();
    #1;
    check("clr_b1_data", bus_a.OUT_DATA, 32'h66666666);
    cyc();
    bus_a.CLR = 1'b1;
    #1;
    check("clr_b2_idx", 32'(bus_a.BEAT_IDX), 2);
    check("clr_cycle_deq", 32'(bus_a.FIFO_DEQ), 0);
    cyc();
    bus_a.CLR = 1'b0;
    #1;
    check("clr_after_valid", 32'(bus_a.OUT_VALID), 0);
    check("clr_after_deq",   32'(bus_a.FIFO_DEQ), 1);
    cyc();
    #1;
    check("clr_restart_valid", 32'(bus_a.OUT_VALID), 1);
    check("clr_restart_idx",   32'(bus_a.BEAT_IDX), 0);
    check("clr_restart_data",  bus_a.OUT_DATA, 32'hFF00FF00);
    cyc();
    #1;
    check("clr_next_idx",  32'(bus_a.BEAT_IDX), 1);
    check("clr_next_data", bus_a.OUT_DATA, 32'h00FF00FF);

    // Async reset mid-word with the FIFO non-empty.
    qa.push_back(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    drive_fifo();
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_valid", 32'(bus_a.OUT_VALID), 0);
    check("ar_deq",   32'(bus_a.FIFO_DEQ), 0);
    check("ar_idx",   32'(bus_a.BEAT_IDX), 0);
    qa.delete();
    drive_fifo();
    cyc();
    #2;
    RST_N = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("ar_idle_valid", 32'(bus_a.OUT_VALID), 0);
      check("ar_idle_deq",   32'(bus_a.FIFO_DEQ), 0);
      cyc();
    end
    qa.push_back(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    drive_fifo();
    #1;
    check("ar_refill_deq", 32'(bus_a.FIFO_DEQ), 1);
    cyc();
    #1;
    check("ar_refill_data", bus_a.OUT_DATA, 32'h76543210);
    check("ar_refill_idx",  32'(bus_a.BEAT_IDX), 0);
    bus_a.OUT_READY = 1'b0;
    cyc();

    // MSB-first instance, same word as the single-word case.
    bus_b.OUT_READY = 1'b1;
    qb.push_back(w1);
    drive_fifo();
    #1;
    check("msb_deq", 32'(bus_b.FIFO_DEQ), 1);
    cyc();
    for (int k = 0; k < R; k++) begin
      #1;
      check("msb_valid", 32'(bus_b.OUT_VALID), 1);
      check("msb_data",  bus_b.OUT_DATA, msb_beats[k]);
      check("msb_idx",   32'(bus_b.BEAT_IDX), k);
      check("msb_last",  32'(bus_b.OUT_LAST), (k == R - 1) ? 1 : 0);
      cyc();
    end
    #1;
    check("msb_idle_valid", 32'(bus_b.OUT_VALID), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
